// File: rtl/exu_pkg.sv
// Shared encodings for the decode stage and the EXU: ALU control, operand-B select,
// branch codes, and the registered EXU result payload.
package exu_pkg;

  localparam int EXU_XLEN = 32;

  // ALU control. Bit 3 selects the unsigned comparison and the sub/arith variants.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [1:0] BSRC_SRC2 = 2'b00;
  localparam logic [1:0] BSRC_IMM  = 2'b01;
  localparam logic [1:0] BSRC_FOUR = 2'b10;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  typedef struct packed {
    logic [EXU_XLEN-1:0] result;
    logic [4:0]          rd;
    logic                wen;
    logic [EXU_XLEN-1:0] next_pc;
    logic                redirect;
    logic                misalign;
  } exu_out_t;

endpackage

// File: rtl/exu_alu.sv
// Team ALU: one result plus compare flags. zero means A == B, less is A < B with
// signedness taken from ctr[3] (1 = unsigned).
module exu_alu
  import exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_ctr_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            less_o
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;

  assign shamt  = b_i[SHW-1:0];
  assign zero_o = (a_i == b_i);
  assign less_o = alu_ctr_i[3] ? (a_i < b_i) : ($signed(a_i) < $signed(b_i));

  always_comb begin
    case (alu_ctr_i)
      ALU_ADD:           result_o = a_i + b_i;
      ALU_SUB:           result_o = a_i - b_i;
      ALU_SLL:           result_o = a_i << shamt;
      ALU_SLT, ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, less_o};
      ALU_XOR:           result_o = a_i ^ b_i;
      ALU_SRL:           result_o = a_i >> shamt;
      ALU_SRA:           result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:            result_o = a_i | b_i;
      ALU_AND:           result_o = a_i & b_i;
      default:           result_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/exu.sv
// Execute stage: operand muxing, ALU, branch resolution and a one-entry
// valid/ready output register with full 1-per-cycle throughput.
module exu
  import exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [3:0]      in_alu_ctr,
  input  logic            in_asrc,
  input  logic [1:0]      in_bsrc,
  input  logic [2:0]      in_branch,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic [XLEN-1:0] out_next_pc,
  output logic            out_redirect,
  output logic            out_misalign
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      state_q, state_d;
  exu_out_t        out_q, out_d;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic            alu_zero, alu_less;
  logic            taken, misalign, xfer_in;
  logic [XLEN-1:0] tgt_base, tgt_sum, target, seq_pc;

  assign alu_a = in_asrc ? in_pc : in_src1;

  always_comb begin
    case (in_bsrc)
      BSRC_SRC2: alu_b = in_src2;
      BSRC_IMM:  alu_b = in_imm;
      BSRC_FOUR: alu_b = XLEN'(4);
      default:   alu_b = in_src2;
    endcase
  end

  exu_alu #(.XLEN(XLEN)) u_alu (
    .alu_ctr_i(in_alu_ctr),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_result),
    .zero_o   (alu_zero),
    .less_o   (alu_less)
  );

  always_comb begin
    case (in_branch)
      BR_NONE:         taken = 1'b0;
      BR_JAL, BR_JALR: taken = 1'b1;
      BR_BEQ:          taken = alu_zero;
      BR_BNE:          taken = !alu_zero;
      BR_BLT:          taken = alu_less;
      BR_BGE:          taken = !alu_less;
      default:         taken = 1'b0;
    endcase
  end

  // Target adder is separate from the ALU so the link value (pc+4) and target coexist.
  assign tgt_base = (in_branch == BR_JALR) ? in_src1 : in_pc;
  assign tgt_sum  = tgt_base + in_imm;
  assign target   = (in_branch == BR_JALR) ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;
  assign seq_pc   = in_pc + XLEN'(4);
  assign misalign = taken && (target[1:0] != 2'b00);

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign xfer_in   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (xfer_in) begin
      state_d = ST_FULL;
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    out_d = out_q;
    if (xfer_in) begin
      out_d.result   = alu_result;
      out_d.rd       = in_rd;
      out_d.wen      = in_wen && !misalign;
      out_d.next_pc  = taken ? target : seq_pc;
      out_d.redirect = taken;
      out_d.misalign = misalign;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign out_result   = out_q.result;
  assign out_rd       = out_q.rd;
  assign out_wen      = out_q.wen;
  assign out_next_pc  = out_q.next_pc;
  assign out_redirect = out_q.redirect;
  assign out_misalign = out_q.misalign;

endmodule

// File: tb/tb_exu.sv
// Bench for exu: directed literal cases plus randomized traffic checked every cycle
// against a queue-based reference model of the execute stage.
module tb_exu;
  import exu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_src1 = '0, in_src2 = '0, in_imm = '0;
  logic [3:0]  in_alu_ctr = '0;
  logic        in_asrc = 1'b0;
  logic [1:0]  in_bsrc = '0;
  logic [2:0]  in_branch = '0;
  logic [4:0]  in_rd = '0;
  logic        in_wen = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [31:0] out_next_pc;
  logic        out_redirect;
  logic        out_misalign;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] next_pc;
    logic        redirect;
    logic        misalign;
  } exp_t;

  exp_t q[$];

  exu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
    .in_alu_ctr(in_alu_ctr), .in_asrc(in_asrc), .in_bsrc(in_bsrc),
    .in_branch(in_branch), .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
    .out_next_pc(out_next_pc), .out_redirect(out_redirect), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: what one instruction must produce, straight from the stage's rules.
  function automatic exp_t model(input logic [31:0] pc, src1, src2, imm,
                                 input logic [3:0] ctr, input logic asrc,
                                 input logic [1:0] bsrc, input logic [2:0] br,
                                 input logic [4:0] rd, input logic wen);
    exp_t e;
    logic [31:0] a, b, tgt;
    logic eq, lt, tk;
    a  = asrc ? pc : src1;
    b  = (bsrc == 2'b01) ? imm : (bsrc == 2'b10) ? 32'd4 : src2;
    eq = (a == b);
    lt = ctr[3] ? (a < b) : ($signed(a) < $signed(b));
    case (ctr)
      ALU_SUB:  e.result = a - b;
      ALU_SLL:  e.result = a << b[4:0];
      ALU_SLT:  e.result = {31'b0, lt};
      ALU_SLTU: e.result = {31'b0, lt};
      ALU_XOR:  e.result = a ^ b;
      ALU_SRL:  e.result = a >> b[4:0];
      ALU_SRA:  e.result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   e.result = a | b;
      ALU_AND:  e.result = a & b;
      default:  e.result = a + b;
    endcase
    case (br)
      3'b001, 3'b010: tk = 1'b1;
      3'b100:         tk = eq;
      3'b101:         tk = !eq;
      3'b110:         tk = lt;
      3'b111:         tk = !lt;
      default:        tk = 1'b0;
    endcase
    tgt        = (br == 3'b010) ? ((src1 + imm) & ~32'h1) : (pc + imm);
    e.next_pc  = tk ? tgt : pc + 32'd4;
    e.redirect = tk;
    e.misalign = tk && (tgt[1:0] != 2'b00);
    e.rd       = rd;
    e.wen      = wen && !e.misalign;
    return e;
  endfunction

  // Scoreboard holds at most the one result the stage may be presenting.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else if (in_valid && (q.size() == 0 || out_ready)) begin
      if (q.size() != 0) void'(q.pop_front());
      q.push_back(model(in_pc, in_src1, in_src2, in_imm, in_alu_ctr, in_asrc,
                        in_bsrc, in_branch, in_rd, in_wen));
    end else if (q.size() != 0 && out_ready) begin
      void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
      chk("cmp_out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("cmp_result", out_result, q[0].result);
        chk("cmp_rd", 32'(out_rd), 32'(q[0].rd));
        chk("cmp_wen", 32'(out_wen), 32'(q[0].wen));
        chk("cmp_next_pc", out_next_pc, q[0].next_pc);
        chk("cmp_redirect", 32'(out_redirect), 32'(q[0].redirect));
        chk("cmp_misalign", 32'(out_misalign), 32'(q[0].misalign));
      end
    end
  end

  // Called at posedge+1; returns at the following negedge with the result presented.
  task automatic issue(input logic [31:0] pc, src1, src2, imm, input logic [3:0] ctr,
                       input logic asrc, input logic [1:0] bsrc, input logic [2:0] br,
                       input logic [4:0] rd, input logic wen);
    in_valid = 1'b1; out_ready = 1'b1;
    in_pc = pc; in_src1 = src1; in_src2 = src2; in_imm = imm; in_alu_ctr = ctr;
    in_asrc = asrc; in_bsrc = bsrc; in_branch = br; in_rd = rd; in_wen = wen;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    $display("issue pc=%h src1=%h src2=%h imm=%h br=%b -> result=%h next_pc=%h redir=%b mis=%b wen=%b",
             pc, src1, src2, imm, br, out_result, out_next_pc, out_redirect, out_misalign, out_wen);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] pick_ctr();
    case ($urandom_range(0, 9))
      0: return ALU_ADD;
      1: return ALU_SUB;
      2: return ALU_SLL;
      3: return ALU_SLT;
      4: return ALU_SLTU;
      5: return ALU_XOR;
      6: return ALU_SRL;
      7: return ALU_SRA;
      8: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_result", out_result, 32'd0);
    chk("reset_next_pc", out_next_pc, 32'd0);
    rst_n = 1'b1;
    settle();

    issue(32'h1000, 32'd5, 32'd7, 32'h99, ALU_ADD, 1'b0, 2'b00, 3'b000, 5'd3, 1'b1);
    chk("add_result", out_result, 32'd12);
    chk("add_redirect", 32'(out_redirect), 32'd0);
    chk("add_next_pc", out_next_pc, 32'h1004);
    chk("add_rd", 32'(out_rd), 32'd3);
    settle();

    issue(32'h1000, 32'd5, 32'd7, 32'd100, ALU_ADD, 1'b0, 2'b11, 3'b011, 5'd4, 1'b1);
    chk("bsrc11_result", out_result, 32'd12);
    chk("br011_redirect", 32'(out_redirect), 32'd0);
    settle();

    issue(32'h100, 32'd0, 32'd0, 32'h20, ALU_ADD, 1'b1, 2'b10, 3'b001, 5'd1, 1'b1);
    chk("jal_result", out_result, 32'h104);
    chk("jal_next_pc", out_next_pc, 32'h120);
    chk("jal_redirect", 32'(out_redirect), 32'd1);
    chk("jal_misalign", 32'(out_misalign), 32'd0);
    settle();

    issue(32'h100, 32'd0, 32'd0, 32'h22, ALU_ADD, 1'b1, 2'b10, 3'b001, 5'd1, 1'b1);
    chk("jal22_misalign", 32'(out_misalign), 32'd1);
    chk("jal22_wen", 32'(out_wen), 32'd0);
    settle();

    issue(32'h300, 32'h203, 32'd0, 32'd0, ALU_ADD, 1'b1, 2'b10, 3'b010, 5'd1, 1'b1);
    chk("jalr203_next_pc", out_next_pc, 32'h202);
    chk("jalr203_misalign", 32'(out_misalign), 32'd1);
    chk("jalr203_result", out_result, 32'h304);
    settle();

    issue(32'h300, 32'h201, 32'd0, 32'd0, ALU_ADD, 1'b1, 2'b10, 3'b010, 5'd1, 1'b1);
    chk("jalr201_next_pc", out_next_pc, 32'h200);
    chk("jalr201_misalign", 32'(out_misalign), 32'd0);
    chk("jalr201_wen", 32'(out_wen), 32'd1);
    settle();

    issue(32'h400, 32'hFFFF_FFFF, 32'd1, 32'h40, ALU_SLT, 1'b0, 2'b00, 3'b110, 5'd0, 1'b0);
    chk("blt_redirect", 32'(out_redirect), 32'd1);
    chk("blt_next_pc", out_next_pc, 32'h440);
    settle();

    issue(32'h400, 32'hFFFF_FFFF, 32'd1, 32'd2, ALU_SLTU, 1'b0, 2'b00, 3'b110, 5'd0, 1'b0);
    chk("bltu_redirect", 32'(out_redirect), 32'd0);
    chk("bltu_next_pc", out_next_pc, 32'h404);
    chk("bltu_misalign", 32'(out_misalign), 32'd0);
    settle();

    // Backpressure: one result held for three stalled cycles, then back-to-back.
    out_ready = 1'b0;
    in_valid = 1'b1; in_alu_ctr = ALU_ADD; in_asrc = 1'b0; in_bsrc = 2'b00;
    in_branch = 3'b000; in_pc = 32'h2000; in_src1 = 32'd100; in_src2 = 32'd1;
    settle();
    in_src1 = 32'd200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_result", out_result, 32'd101);
      $display("stall cycle %0d result=%h in_ready=%b", i, out_result, in_ready);
      settle();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_src1 = 32'(200 + j);
      settle();
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_result", out_result, 32'(201 + j));
      $display("b2b %0d result=%h", j, out_result);
    end
    in_valid = 1'b0;
    settle();

    // Reset while full and stalled clears without a clock edge.
    out_ready = 1'b0;
    in_valid = 1'b1; in_src1 = 32'd50; in_src2 = 32'd0; in_rd = 5'd9; in_wen = 1'b1;
    settle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_result", out_result, 32'd0);
    chk("arst_rd", 32'(out_rd), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    $display("async reset out_valid=%b result=%h", out_valid, out_result);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    in_valid = 1'b1; out_ready = 1'b1; in_src1 = 32'd9; in_src2 = 32'd9;
    settle();
    chk("post_reset_valid", 32'(out_valid), 32'd1);
    chk("post_reset_result", out_result, 32'd18);
    in_valid = 1'b0;
    settle();

    for (int n = 0; n < 800; n++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 7);
      in_pc      = $urandom() & 32'hFFFF_FFFC;
      in_src1    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
      in_src2    = ($urandom_range(0, 2) == 0) ? in_src1 :
                   (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom());
      in_imm     = ($urandom_range(0, 1) == 0) ? 32'(int'($urandom_range(0, 64)) - 32) : $urandom();
      in_alu_ctr = pick_ctr();
      in_asrc    = 1'($urandom_range(0, 1));
      in_bsrc    = 2'($urandom_range(0, 3));
      in_branch  = 3'($urandom_range(0, 7));
      in_rd      = 5'($urandom_range(0, 31));
      in_wen     = 1'($urandom_range(0, 1));
      settle();
      if (n % 100 == 0) $display("random step %0d checks=%0d", n, checks);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exu.md
EXU -- requirements
Module: exu

Interface
REQ-001 The block SHALL provide parameter XLEN, default 32: datapath width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  the decode stage offers a decoded instruction.
REQ-005 in_ready  output  1  the EXU can accept the offered instruction this cycle.
REQ-006 in_pc, in_src1, in_src2, in_imm  input  32 each  instruction PC, rs1 value, rs2 value, sign-extended immediate.
REQ-007 in_alu_ctr  input  4  ALU control, using the team's existing 4-bit ALU encoding.
REQ-008 in_asrc  input  1  ALU operand A select: 0 = src1, 1 = pc.
REQ-009 in_bsrc  input  2  ALU operand B select: 00 = src2, 01 = imm, 10 = 32'd4; 11 is reserved and SHALL act as 00.
REQ-010 in_branch  input  3  branch code: 000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt/bltu, 111 bge/bgeu; other codes SHALL act as 000.
REQ-011 in_rd  input  5  destination register index.
REQ-012 in_wen  input  1  register-write enable.
REQ-013 out_valid  output  1  a result is held for the downstream stage.
REQ-014 out_ready  input  1  the downstream stage accepts the held result.
REQ-015 out_result  output  32  ALU result.
REQ-016 out_rd  output  5  registered copy of in_rd.
REQ-017 out_wen  output  1  registered copy of in_wen, forced to 0 when out_misalign = 1.
REQ-018 out_next_pc  output  32  next PC.
REQ-019 out_redirect  output  1  next PC is not pc+4.
REQ-020 out_misalign  output  1  a redirect target is not 4-byte aligned.

Function
REQ-021 Operands SHALL be A = in_asrc ? in_pc : in_src1 and B as selected by in_bsrc, both computed combinationally into one ALU instance.
REQ-022 The taken condition SHALL be: beq = zero; bne = !zero; blt = less; bge = !less; jal and jalr = 1; none = 0. Signedness comes from in_alu_ctr[3] as decoded upstream.
REQ-023 The target SHALL be: jalr = (src1 + imm) & ~32'h1; all other codes = pc + imm. The target uses a dedicated adder, not the ALU.
REQ-024 Next PC SHALL be: next_pc = taken ? target : pc + 4, and redirect = taken; all additions wrap modulo 2^32.
REQ-025 Misalignment SHALL be: misalign = taken && (target[1:0] != 0). A not-taken branch SHALL never flag misalign.
REQ-026 in_ready SHALL be (!out_valid || out_ready), combinational; in_ready SHALL NOT depend on in_valid.
REQ-027 A transfer in SHALL occur when in_valid && in_ready; the output register SHALL then load all out_* payload from the combinational results and set out_valid = 1 on the next edge.
REQ-028 When out_valid && out_ready and no transfer in occurs, out_valid SHALL be 0 on the next edge.
REQ-029 When a transfer out and a transfer in occur in the same cycle, out_valid SHALL stay 1, the new payload SHALL load, and throughput SHALL be 1 instruction/cycle.
REQ-030 While out_valid && !out_ready, all out_* SHALL hold stable, with no payload change.
REQ-031 Latency SHALL be exactly 1 cycle from transfer in to out_valid.
REQ-032 The state machine SHALL have two states, EMPTY (out_valid = 0) and FULL (out_valid = 1); transitions follow REQ-027 to REQ-029.

Reset
REQ-033 Asserting rst_n low SHALL asynchronously clear out_valid and all payload registers to 0, including mid-stall.
REQ-034 An instruction held at reset SHALL be discarded.
REQ-035 After rst_n deasserts, the first transfer in SHALL be possible in the first cycle, since in_ready = 1.

Structure
REQ-036 A shared package SHALL hold the in_branch codes, in_bsrc codes and the ALU control constants; the decoder and the EXU SHALL both import it.
REQ-037 The one sub-module SHALL be the existing ALU, instantiated once; branch evaluation and the target adder SHALL stay inline in the EXU.

Verification
REQ-038 Add: src1=5, src2=7, ctr=add, bsrc=00, branch=000 -> next cycle out_result=12, out_redirect=0, out_next_pc=pc+4.
REQ-039 jal: pc=0x100, imm=0x20, asrc=1, bsrc=10 -> out_result=0x104, out_next_pc=0x120, redirect=1; the same with imm=0x22 -> misalign=1, wen=0.
REQ-040 jalr: src1=0x203, imm=0 -> target=0x202, misalign=1; with src1=0x201 -> target=0x200, misalign=0.
REQ-041 Branches: blt signed with src1=0xFFFFFFFF, src2=1 -> taken. bltu (ctr[3]=1) with the same operands -> not taken, next_pc=pc+4, misalign=0 even with imm=2.
REQ-042 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and payload stable; then out_ready=1 -> back-to-back transfers, one per cycle, no loss or duplication.
REQ-043 Reset: assert rst_n=0 while FULL and stalled -> out_valid=0 immediately, without a clock edge.
